// File: rtl/fp32_maxmin_reduce.sv
// Vector max/min reduction sequencer: pairs a running accumulator with each new
// FP32 element, issues it to the external compare stage and folds the result back.
module fp32_maxmin_reduce #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_is_max,
    input  logic             i_valid,
    input  logic [31:0]      i_data,
    input  logic             i_last,
    output logic             o_ready,
    output logic             o_cmp_valid,
    output logic             o_cmp_is_max,
    output logic [31:0]      o_cmp_a,
    output logic [31:0]      o_cmp_b,
    input  logic             i_cmp_res_valid,
    input  logic [31:0]      i_cmp_res,
    output logic             o_res_valid,
    output logic [31:0]      o_res,
    output logic [CNT_W-1:0] o_res_cnt,
    output logic             o_busy,
    output logic             o_err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FIRST = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_CMP   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam int              TMO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    logic [2:0]       state;
    logic             is_max_q;
    logic             last_q;
    logic             err_q;
    logic [31:0]      acc;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [TMO_W-1:0] tmo;
    logic             accept;
    logic             data_is_nan;

    assign o_ready     = (state == S_FIRST) || (state == S_WAIT);
    assign o_busy      = (state != S_IDLE);
    assign accept      = i_valid & o_ready;
    assign cnt_inc     = (&cnt) ? cnt : cnt + CNT_W'(1);
    assign data_is_nan = (i_data[30:23] == 8'hFF) && (i_data[22:0] != 23'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            is_max_q     <= 1'b0;
            last_q       <= 1'b0;
            err_q        <= 1'b0;
            acc          <= '0;
            cnt          <= '0;
            tmo          <= '0;
            o_cmp_valid  <= 1'b0;
            o_cmp_is_max <= 1'b0;
            o_cmp_a      <= '0;
            o_cmp_b      <= '0;
            o_res_valid  <= 1'b0;
            o_res        <= '0;
            o_res_cnt    <= '0;
            o_err        <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout so every branch sees pre-edge state;
            // the pulse outputs default low here and are raised for one cycle below.
            o_cmp_valid <= 1'b0;
            o_res_valid <= 1'b0;
            o_err       <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        is_max_q <= i_is_max;
                        cnt      <= '0;
                        state    <= S_FIRST;
                    end
                end
                S_FIRST: begin
                    if (accept) begin
                        cnt <= CNT_W'(1);
                        if (i_last) begin
                            // A lone element never passes the comparator, so NaN is canonicalised here.
                            acc   <= data_is_nan ? 32'hFFFF_FFFF : i_data;
                            state <= S_DONE;
                        end else begin
                            acc   <= i_data;
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (accept) begin
                        o_cmp_a      <= acc;
                        o_cmp_b      <= i_data;
                        o_cmp_is_max <= is_max_q;
                        o_cmp_valid  <= 1'b1;
                        last_q       <= i_last;
                        cnt          <= cnt_inc;
                        tmo          <= '0;
                        state        <= S_CMP;
                    end
                end
                S_CMP: begin
                    if (i_cmp_res_valid) begin
                        acc   <= i_cmp_res;
                        state <= last_q ? S_DONE : S_WAIT;
                    end else if (tmo == TMO_LAST) begin
                        acc   <= 32'hFFFF_FFFF;
                        err_q <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        tmo <= tmo + TMO_W'(1);
                    end
                end
                S_DONE: begin
                    o_res_valid <= 1'b1;
                    o_res       <= acc;
                    o_res_cnt   <= cnt;
                    o_err       <= err_q;
                    err_q       <= 1'b0;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp32_maxmin_reduce.sv
// Directed bench for fp32_maxmin_reduce with a behavioural 2-cycle FP32 compare
// stage attached to the compare request/result ports.
module tb_fp32_maxmin_reduce;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_start = 1'b0;
    logic        i_is_max = 1'b0;
    logic        i_valid = 1'b0;
    logic [31:0] i_data = '0;
    logic        i_last = 1'b0;
    logic        o_ready;
    logic        o_cmp_valid;
    logic        o_cmp_is_max;
    logic [31:0] o_cmp_a;
    logic [31:0] o_cmp_b;
    logic        i_cmp_res_valid;
    logic [31:0] i_cmp_res;
    logic        o_res_valid;
    logic [31:0] o_res;
    logic [15:0] o_res_cnt;
    logic        o_busy;
    logic        o_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fp32_maxmin_reduce #(.CNT_W(16), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .i_start(i_start), .i_is_max(i_is_max),
        .i_valid(i_valid), .i_data(i_data), .i_last(i_last), .o_ready(o_ready),
        .o_cmp_valid(o_cmp_valid), .o_cmp_is_max(o_cmp_is_max),
        .o_cmp_a(o_cmp_a), .o_cmp_b(o_cmp_b),
        .i_cmp_res_valid(i_cmp_res_valid), .i_cmp_res(i_cmp_res),
        .o_res_valid(o_res_valid), .o_res(o_res), .o_res_cnt(o_res_cnt),
        .o_busy(o_busy), .o_err(o_err)
    );

    // Behavioural compare stage: NaN in -> 0xFFFFFFFF, otherwise signed-magnitude ordering.
    function automatic logic [31:0] fp_cmp(input logic [31:0] a, input logic [31:0] b, input logic mx);
        logic        a_nan, b_nan, a_gt;
        logic [31:0] ka, kb;
        a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        if (a_nan || b_nan) return 32'hFFFF_FFFF;
        ka   = a[31] ? ~a : {1'b1, a[30:0]};
        kb   = b[31] ? ~b : {1'b1, b[30:0]};
        a_gt = ka > kb;
        return (mx ? a_gt : !a_gt) ? a : b;
    endfunction

    logic        cmp_en = 1'b1;
    logic        inj_v  = 1'b0;
    logic [31:0] inj_r  = '0;
    logic        s1_v = 1'b0, s2_v = 1'b0;
    logic [31:0] s1_r = '0, s2_r = '0;

    always @(posedge clk) begin
        s1_v <= o_cmp_valid & cmp_en;
        s1_r <= fp_cmp(o_cmp_a, o_cmp_b, o_cmp_is_max);
        s2_v <= s1_v;
        s2_r <= s1_r;
    end

    assign i_cmp_res_valid = s2_v | inj_v;
    assign i_cmp_res       = inj_v ? inj_r : s2_r;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: counts pulses and keeps the last result and compare operands.
    int          n_cmp = 0, n_res = 0, res_cyc = 0;
    logic [31:0] res_v = '0;
    logic [15:0] cnt_v = '0;
    logic        err_v = 1'b0;
    logic [31:0] log_a[$], log_b[$];
    logic        log_m[$];

    always @(negedge clk) begin
        if (o_cmp_valid) begin
            n_cmp <= n_cmp + 1;
            log_a.push_back(o_cmp_a);
            log_b.push_back(o_cmp_b);
            log_m.push_back(o_cmp_is_max);
        end
        if (o_res_valid) begin
            n_res   <= n_res + 1;
            res_v   <= o_res;
            cnt_v   <= o_res_cnt;
            err_v   <= o_err;
            res_cyc <= cyc;
        end
    end

    logic [31:0] vec[4];
    int          acc_cyc[4];

    task automatic start_red(input logic mx);
        i_is_max = mx;
        i_start  = 1'b1;
        @(posedge clk); #1;
        i_start  = 1'b0;
        i_is_max = 1'b0;
    endtask

    task automatic push(input logic [31:0] d, input logic l, input logic keep, output int c);
        c = -1;
        i_valid = 1'b1;
        i_data  = d;
        i_last  = l;
        for (int k = 0; k < 40; k++) begin
            if (o_ready) begin
                @(posedge clk); #1;
                c = cyc;
                break;
            end
            @(posedge clk); #1;
        end
        if (!keep) begin
            i_valid = 1'b0;
            i_last  = 1'b0;
        end
        if (c < 0) begin
            checks++; failures++;
            $display("FAIL accept_timeout: element %h not accepted within 40 cycles", d);
        end
    endtask

    task automatic run_vec(input logic mx, input int n, input logic keep);
        log_a.delete(); log_b.delete(); log_m.delete();
        start_red(mx);
        for (int i = 0; i < n; i++) push(vec[i], (i == n - 1), keep, acc_cyc[i]);
    endtask

    task automatic wait_res(input int n0, input int lim, input string nm);
        int k = 0;
        while (n_res == n0 && k < lim) begin
            @(posedge clk); #1;
            k++;
        end
        checks++;
        if (n_res == n0) begin
            failures++;
            $display("FAIL %s_res_valid: no o_res_valid within %0d cycles", nm, lim);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({o_busy, o_ready, o_cmp_valid, o_res_valid, o_err, o_cmp_is_max} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got busy/rdy/cv/rv/err/ismax=%b want 000000",
                     {o_busy, o_ready, o_cmp_valid, o_res_valid, o_err, o_cmp_is_max});
        end
        checks++;
        if ({o_res, o_res_cnt, o_cmp_a, o_cmp_b} !== 112'd0) begin
            failures++;
            $display("FAIL reset_data: got res=%h cnt=%h a=%h b=%h want all zero", o_res, o_res_cnt, o_cmp_a, o_cmp_b);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_max4;
        int n0 = n_res, c0 = n_cmp;
        vec = '{32'h3F80_0000, 32'hC000_0000, 32'h4060_0000, 32'h3F00_0000};
        run_vec(1'b1, 4, 1'b0);
        wait_res(n0, 40, "max4");
        checks++;
        if (res_v !== 32'h4060_0000) begin failures++; $display("FAIL max4_res: got %h want 40600000", res_v); end
        checks++;
        if (cnt_v !== 16'd4 || err_v !== 1'b0) begin failures++; $display("FAIL max4_cnt_err: got cnt=%0d err=%b want cnt=4 err=0", cnt_v, err_v); end
        checks++;
        if (n_cmp - c0 !== 3) begin failures++; $display("FAIL max4_ncmp: got %0d want 3", n_cmp - c0); end
        checks++;
        if ({log_a[0], log_b[0], log_a[1], log_b[1], log_a[2], log_b[2]} !==
            {32'h3F80_0000, 32'hC000_0000, 32'h3F80_0000, 32'h4060_0000, 32'h4060_0000, 32'h3F00_0000}) begin
            failures++;
            $display("FAIL max4_operands: got (%h,%h)(%h,%h)(%h,%h) want (3f800000,c0000000)(3f800000,40600000)(40600000,3f000000)",
                     log_a[0], log_b[0], log_a[1], log_b[1], log_a[2], log_b[2]);
        end
        checks++;
        if ({log_m[0], log_m[1], log_m[2]} !== 3'b111) begin failures++; $display("FAIL max4_is_max: got %b want 111", {log_m[0], log_m[1], log_m[2]}); end
        checks++;
        if (acc_cyc[1] - acc_cyc[0] !== 1 || acc_cyc[2] - acc_cyc[1] !== 4 || acc_cyc[3] - acc_cyc[2] !== 4) begin
            failures++;
            $display("FAIL max4_spacing: got %0d/%0d/%0d want 1/4/4", acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1], acc_cyc[3] - acc_cyc[2]);
        end
        checks++;
        if (res_cyc - acc_cyc[3] !== 4) begin failures++; $display("FAIL max4_latency: got %0d want 4", res_cyc - acc_cyc[3]); end
    endtask

    task automatic test_min4;
        int n0 = n_res;
        vec = '{32'h3F80_0000, 32'hC000_0000, 32'h4060_0000, 32'h3F00_0000};
        run_vec(1'b0, 4, 1'b0);
        wait_res(n0, 40, "min4");
        checks++;
        if (res_v !== 32'hC000_0000) begin failures++; $display("FAIL min4_res: got %h want c0000000", res_v); end
        checks++;
        if (cnt_v !== 16'd4) begin failures++; $display("FAIL min4_cnt: got %0d want 4", cnt_v); end
        checks++;
        if ({log_m[0], log_m[1], log_m[2]} !== 3'b000) begin failures++; $display("FAIL min4_is_max: got %b want 000", {log_m[0], log_m[1], log_m[2]}); end
    endtask

    task automatic test_single_nan;
        int n0 = n_res, c0 = n_cmp;
        vec[0] = 32'h7FC0_0001;
        run_vec(1'b1, 1, 1'b0);
        wait_res(n0, 20, "single");
        checks++;
        if (res_v !== 32'hFFFF_FFFF) begin failures++; $display("FAIL single_res: got %h want ffffffff", res_v); end
        checks++;
        if (cnt_v !== 16'd1 || err_v !== 1'b0) begin failures++; $display("FAIL single_cnt_err: got cnt=%0d err=%b want 1/0", cnt_v, err_v); end
        checks++;
        if (n_cmp - c0 !== 0) begin failures++; $display("FAIL single_ncmp: got %0d want 0", n_cmp - c0); end
        checks++;
        if (res_cyc - acc_cyc[0] !== 1) begin failures++; $display("FAIL single_latency: got %0d want 1", res_cyc - acc_cyc[0]); end
    endtask

    task automatic test_nan_hold;
        int n0 = n_res;
        vec = '{32'h3F80_0000, 32'h7F80_0001, 32'h4000_0000, 32'h0};
        i_valid = 1'b1; i_data = vec[0]; i_last = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (o_ready !== 1'b0) begin failures++; $display("FAIL idle_ready: got %b want 0", o_ready); end
        run_vec(1'b1, 3, 1'b1);
        wait_res(n0, 40, "nanhold");
        checks++;
        if (res_v !== 32'hFFFF_FFFF || cnt_v !== 16'd3) begin failures++; $display("FAIL nanhold_res: got %h cnt=%0d want ffffffff cnt=3", res_v, cnt_v); end
        checks++;
        if (acc_cyc[1] - acc_cyc[0] !== 1 || acc_cyc[2] - acc_cyc[1] !== 4) begin
            failures++;
            $display("FAIL nanhold_spacing: got %0d/%0d want 1/4", acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1]);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (o_ready !== 1'b0 || o_busy !== 1'b0 || n_res - n0 !== 1) begin
            failures++;
            $display("FAIL nanhold_idle: got ready=%b busy=%b results=%0d want 0/0/1", o_ready, o_busy, n_res - n0);
        end
        i_valid = 1'b0; i_last = 1'b0;
    endtask

    task automatic test_timeout;
        int n0 = n_res;
        cmp_en = 1'b0;
        vec = '{32'h3F80_0000, 32'h4000_0000, 32'h0, 32'h0};
        run_vec(1'b1, 2, 1'b0);
        wait_res(n0, 60, "timeout");
        checks++;
        if (err_v !== 1'b1 || res_v !== 32'hFFFF_FFFF || cnt_v !== 16'd2) begin
            failures++;
            $display("FAIL timeout_res: got err=%b res=%h cnt=%0d want 1/ffffffff/2", err_v, res_v, cnt_v);
        end
        checks++;
        if (res_cyc - acc_cyc[1] !== 16) begin failures++; $display("FAIL timeout_latency: got %0d want 16", res_cyc - acc_cyc[1]); end
        checks++;
        if (o_err !== 1'b0) begin failures++; $display("FAIL timeout_err_pulse: got %b want 0", o_err); end
        cmp_en = 1'b1;
    endtask

    task automatic test_reset_mid;
        int n0 = n_res;
        int c;
        cmp_en = 1'b0;
        start_red(1'b1);
        push(32'h3F80_0000, 1'b0, 1'b0, c);
        push(32'h4000_0000, 1'b1, 1'b0, c);
        rst = 1'b1;
        @(posedge clk); #1;
        rst   = 1'b0;
        inj_v = 1'b1;
        inj_r = 32'h1234_5678;
        @(posedge clk); #1;
        inj_v = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (o_busy !== 1'b0 || n_res !== n0 || o_res !== 32'h0) begin
            failures++;
            $display("FAIL rstmid_abort: got busy=%b results=%0d res=%h want 0/0/00000000", o_busy, n_res - n0, o_res);
        end
        cmp_en = 1'b1;
        n0 = n_res;
        vec = '{32'h3F80_0000, 32'h4000_0000, 32'h0, 32'h0};
        run_vec(1'b1, 2, 1'b0);
        wait_res(n0, 40, "rstmid");
        checks++;
        if (res_v !== 32'h4000_0000 || cnt_v !== 16'd2 || err_v !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_after: got res=%h cnt=%0d err=%b want 40000000/2/0", res_v, cnt_v, err_v);
        end
    endtask

    initial begin
        test_reset;
        test_max4;
        test_min4;
        test_single_nan;
        test_nan_hold;
        test_timeout;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
